bram_pattern_engine: RTL

Fabric-side initiator on the 32-bit BRAM port of the DMA test BRAM, the counterpart to the AXI BRAM controller in the processor system. On command it either fills a span of BRAM words with a deterministic pattern, for the PS DMA to read back, or reads a span and checks it against the pattern the PS DMA was expected to write. It reports busy, done and error status for software or ILA observation.

---
 rtl/bram_pattern_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bram_pattern_engine.sv
// Fabric-side BRAM pattern fill/check engine: writes a deterministic word pattern or reads one back and counts mismatches.
// Optional build macro BRAM_PATTERN_LFSR_EN swaps the incrementing pattern for a 32-bit Galois LFSR.
module bram_pattern_engine #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       seed,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, FIN} state_t;

`ifdef BRAM_PATTERN_LFSR_EN
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] pat_first(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return (p >> 1) ^ (p[0] ? LFSR_MASK : 32'h0);
    endfunction
`else
    function automatic logic [31:0] pat_first(input logic [31:0] s);
        return s;
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return p + 32'd1;
    endfunction
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [31:0]        pat, pat_d;
    logic               busy_d, done_d, en_d;
    logic [3:0]         we_d;
    logic [ADDR_W+1:0]  addr_d;
    logic [31:0]        din_d;
    logic [CNT_W-1:0]   len_last;

    logic [RD_LAT-1:0]  pipe_vld;
    logic [31:0]        pipe_exp [RD_LAT];
    logic [ADDR_W-1:0]  pipe_adr [RD_LAT];
    logic               mismatch;

    // len == 0 encodes a full 2^ADDR_W span, so its last index is all ones in ADDR_W bits.
    assign len_last = (len == '0) ? {1'b0, {ADDR_W{1'b1}}} : len - CNT_W'(1);
    assign mismatch = pipe_vld[RD_LAT-1] && (bram_dout != pipe_exp[RD_LAT-1]);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d = state;
        cnt_d   = cnt;
        last_d  = last_q;
        pat_d   = pat;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        en_d    = 1'b0;
        we_d    = 4'h0;
        addr_d  = '0;
        din_d   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    last_d  = len_last;
                    cnt_d   = '0;
                    pat_d   = pat_first(seed);
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    state_d = mode ? READ : FILL;
                    if (!mode) begin
                        we_d  = 4'hF;
                        din_d = pat_d;
                    end
                end
            end
            FILL, READ: begin
                busy_d = 1'b1;
                if (cnt == last_q) begin
                    cnt_d = '0;
                    if (state == FILL) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d  = cnt + CNT_W'(1);
                    pat_d  = pat_next(pat);
                    en_d   = 1'b1;
                    addr_d = {cnt_d[ADDR_W-1:0], 2'b00};
                    if (state == FILL) begin
                        we_d  = 4'hF;
                        din_d = pat_d;
                    end
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state          <= IDLE;
            cnt            <= '0;
            last_q         <= '0;
            pat            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bram_en        <= 1'b0;
            bram_we        <= 4'h0;
            bram_addr      <= '0;
            bram_din       <= '0;
            pipe_vld       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last_q    <= last_d;
            pat       <= pat_d;
            busy      <= busy_d;
            done      <= done_d;
            bram_en   <= en_d;
            bram_we   <= we_d;
            bram_addr <= addr_d;
            bram_din  <= din_d;
            pipe_vld[0] <= (state == READ);
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            if (state == IDLE && start && mode) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'h0) first_err_addr <= pipe_adr[RD_LAT-1];
            end
        end
    end

    // NOTE: the expected-data pipeline carries no reset; only its valid bits need clearing.
    always_ff @(posedge axi_aclk) begin
        pipe_exp[0] <= pat;
        pipe_adr[0] <= cnt[ADDR_W-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_exp[i] <= pipe_exp[i-1];
            pipe_adr[i] <= pipe_adr[i-1];
        end
    end

endmodule
